// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver.
//  - PS2_BREAK / PS2_EXT : set-2 prefix bytes for a key release and an extended key
//  - ps2_state_t         : frame FSM states, one state per part of the 11-bit frame
// -----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_clk_filter.sv
// -----------------------------------------------------------------------------
// ps2_clk_filter
// Brings one raw PS/2 pin into the clk domain and removes glitches.
// The filtered level only changes after FILTER_LEN consecutive synchronised
// samples that all disagree with it. The same block serves the clock pin
// (where the fall pulse is used) and the data pin (where only level is used).
// Ports:
//  clk   in   system clock
//  rst   in   synchronous active-high reset (everything presets to the idle-high bus)
//  pin   in   raw asynchronous pin
//  level out  filtered pin level
//  fall  out  one-cycle pulse in the cycle level has just gone 1->0
// -----------------------------------------------------------------------------
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser feeding a run-length counter. The counter only
    // advances while the synced pin disagrees with the filtered level and
    // clears as soon as they agree, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// -----------------------------------------------------------------------------
// ps2_keyboard_rx
// Receives device-to-host PS/2 keyboard frames and keeps the make code of the
// key currently held, which drives the tone generator's note select.
// Ports:
//  clk         in   50 MHz system clock
//  rst         in   synchronous active-high reset
//  ps2_clk     in   raw PS/2 clock pin
//  ps2_data    in   raw PS/2 data pin
//  scan_code   out  held make code, 8'h00 when no key is down
//  make_strobe out  one-cycle pulse per accepted make byte (typematic repeats too)
//  rx_byte     out  last correctly framed byte, raw
//  rx_valid    out  one-cycle pulse when rx_byte updates
//  frame_err   out  one-cycle pulse on parity, stop-bit or timeout failure
// -----------------------------------------------------------------------------
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       make_strobe,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TOUT_PRE = TW'(TIMEOUT_CYC - 2);
    localparam logic [TW-1:0] TOUT_MAX = {TW{1'b1}};

    ps2_state_t    state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_q, par_n;
    logic [TW-1:0] tout_cnt, tout_n;
    logic          fall;
    logic          data_s;
    logic          frame_good;
    logic          frame_bad;
    logic          tout_hit;
    logic          break_pending;
    logic          clk_level_unused;
    logic          data_fall_unused;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_clk),
        .level (clk_level_unused),
        .fall  (fall)
    );

    // The data pin goes through an identical filter so it sees the same
    // latency as the clock and is still stable when the filtered fall arrives.
    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_data),
        .level (data_s),
        .fall  (data_fall_unused)
    );

    // The abort fires on the edge where the count reaches TIMEOUT_CYC-1, which
    // puts the frame_err pulse exactly TIMEOUT_CYC cycles after the last fall.
    // A fall in the same cycle takes priority and restarts the count.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        par_n      = par_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        tout_hit   = (state != IDLE) && !fall && (tout_cnt == TOUT_PRE);

        if (fall || state == IDLE) begin
            tout_n = '0;
        end else if (tout_cnt != TOUT_MAX) begin
            tout_n = tout_cnt + TW'(1);
        end else begin
            tout_n = tout_cnt;
        end

        if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_n   = DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                DATA: begin
                    shreg_n   = {data_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    par_n   = data_s;
                    state_n = STOP;
                end
                STOP: begin
                    if (data_s && (^{shreg, par_q})) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end else if (tout_hit) begin
            state_n   = IDLE;
            frame_bad = 1'b1;
        end
    end

    // Frame FSM registers plus the registered frame-level result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            par_q     <= 1'b0;
            tout_cnt  <= '0;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            par_q     <= par_n;
            tout_cnt  <= tout_n;
            rx_valid  <= frame_good;
            frame_err <= frame_bad;
            if (frame_good) begin
                rx_byte <= shreg;
            end
        end
    end

    // Set-2 decode: F0 arms a break, E0 is dropped so extended keys look like
    // their base code, and a break only clears scan_code if it names the key
    // that is currently held.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_code     <= 8'h00;
            make_strobe   <= 1'b0;
            break_pending <= 1'b0;
        end else begin
            make_strobe <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == PS2_BREAK) begin
                    break_pending <= 1'b1;
                end else if (rx_byte == PS2_EXT) begin
                    break_pending <= break_pending;
                end else if (break_pending) begin
                    if (rx_byte == scan_code) begin
                        scan_code <= 8'h00;
                    end
                    break_pending <= 1'b0;
                end else begin
                    scan_code   <= rx_byte;
                    make_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_keyboard_rx
// Drives PS/2 frames into ps2_keyboard_rx and compares the decoded results
// against a set-2 key-state model kept here. The timeout is shortened so the
// whole run stays small.
// -----------------------------------------------------------------------------
module tb_ps2_keyboard_rx;

    localparam int FL  = 8;
    localparam int TO  = 1500;
    localparam int LAT = FL + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       make_strobe;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         rx_cnt = 0;
    int         rx_cyc = -1;
    logic [7:0] rx_last = 8'h00;
    int         ms_cnt = 0;
    int         ms_cyc = -1;
    logic [7:0] ms_scan = 8'h00;
    int         fe_cnt = 0;
    int         fe_cyc = -1;

    logic [7:0] m_scan = 8'h00;
    bit         m_pending = 1'b0;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .make_strobe (make_strobe),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_cnt  = rx_cnt + 1;
            rx_cyc  = cyc;
            rx_last = rx_byte;
        end
        if (make_strobe === 1'b1) begin
            ms_cnt  = ms_cnt + 1;
            ms_cyc  = cyc;
            ms_scan = scan_code;
        end
        if (frame_err === 1'b1) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
    end

    // Key-state model from the set-2 rules; returns 1 when a make pulse is due.
    function automatic bit model_decode(input logic [7:0] b);
        if (b == 8'hF0) begin
            m_pending = 1'b1;
            return 1'b0;
        end
        if (b == 8'hE0) return 1'b0;
        if (m_pending) begin
            if (b == m_scan) m_scan = 8'h00;
            m_pending = 1'b0;
            return 1'b0;
        end
        m_scan = b;
        return 1'b1;
    endfunction

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = (~^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the low nbits of a frame, LSB first, one bit per ps2_clk low pulse.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch, output int last_fall);
        last_fall = -1;
        for (int i = 0; i < nbits; i++) begin
            int hp;
            hp = $urandom_range(16, 24);
            ps2_data = bits[i];
            wait_cycles(hp);
            if (glitch) begin
                ps2_clk = 1'b0;
                wait_cycles(3);
                ps2_clk = 1'b1;
                wait_cycles(hp);
            end
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wait_cycles(hp);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch, output int fall);
        send_bits(mk_frame(b, bad_par, bad_stop), 11, glitch, fall);
        wait_cycles(10);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(5);
        checks++;
        if (scan_code !== 8'h00) begin errors++; $display("[TB] FAIL reset_scan_code got %h expected 00", scan_code); end
        checks++;
        if (rx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_byte got %h expected 00", rx_byte); end
        checks++;
        if ({rx_valid, make_strobe, frame_err} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_pulses got %b expected 000", {rx_valid, make_strobe, frame_err});
        end
        rst = 1'b0;
        m_scan = 8'h00;
        m_pending = 1'b0;
        wait_cycles(LAT + 10);
        checks++;
        if (rx_cnt + ms_cnt + fe_cnt != 0) begin
            errors++; $display("[TB] FAIL reset_quiet got %0d events expected 0", rx_cnt + ms_cnt + fe_cnt);
        end
    endtask

    task automatic test_single_make();
        int f, rx0, ms0;
        bit exp_ms;
        rx0 = rx_cnt; ms0 = ms_cnt;
        send_byte(8'h1C, 1'b0, 1'b0, 1'b0, f);
        exp_ms = model_decode(8'h1C);
        checks++;
        if (rx_cnt - rx0 != 1 || rx_last !== 8'h1C) begin
            errors++; $display("[TB] FAIL make_rx got %0d pulses byte %h expected 1 pulse byte 1c", rx_cnt - rx0, rx_last);
        end
        checks++;
        if (rx_cyc != f + LAT + 1) begin errors++; $display("[TB] FAIL make_rx_timing got cycle %0d expected %0d", rx_cyc, f + LAT + 1); end
        checks++;
        if (ms_cnt - ms0 != int'(exp_ms) || ms_cyc != f + LAT + 2) begin
            errors++; $display("[TB] FAIL make_strobe got %0d pulses at %0d expected %0d at %0d", ms_cnt - ms0, ms_cyc, exp_ms, f + LAT + 2);
        end
        checks++;
        if (scan_code !== m_scan || ms_scan !== m_scan) begin
            errors++; $display("[TB] FAIL make_scan got %h/%h expected %h", scan_code, ms_scan, m_scan);
        end
    endtask

    // Runs a byte list through the DUT and model, checking scan_code after each.
    task automatic run_list(input string name, input logic [7:0] seq[$]);
        int f, ms0, exp_ms;
        ms0 = ms_cnt; exp_ms = 0;
        foreach (seq[i]) begin
            send_byte(seq[i], 1'b0, 1'b0, 1'b0, f);
            if (model_decode(seq[i])) exp_ms++;
            checks++;
            if (rx_last !== seq[i] || rx_cyc != f + LAT + 1) begin
                errors++; $display("[TB] FAIL %s_rx[%0d] got %h at %0d expected %h at %0d", name, i, rx_last, rx_cyc, seq[i], f + LAT + 1);
            end
            checks++;
            if (scan_code !== m_scan) begin errors++; $display("[TB] FAIL %s_scan[%0d] got %h expected %h", name, i, scan_code, m_scan); end
        end
        checks++;
        if (ms_cnt - ms0 != exp_ms) begin errors++; $display("[TB] FAIL %s_strobes got %0d expected %0d", name, ms_cnt - ms0, exp_ms); end
    endtask

    task automatic test_make_break();
        run_list("make_break", '{8'h1C, 8'hF0, 8'h1C});
        checks++;
        if (scan_code !== 8'h00) begin errors++; $display("[TB] FAIL make_break_final got %h expected 00", scan_code); end
        run_list("double_break", '{8'h2A, 8'hF0, 8'hF0, 8'h2A, 8'hE0, 8'h75});
    endtask

    task automatic test_no_break_switch();
        run_list("switch", '{8'h1C, 8'h1B, 8'hF0, 8'h1C});
        checks++;
        if (scan_code !== 8'h1B) begin errors++; $display("[TB] FAIL switch_final got %h expected 1b", scan_code); end
    endtask

    task automatic test_frame_errors();
        int f, rx0, fe0;
        run_list("err_setup", '{8'h33, 8'hF0});
        rx0 = rx_cnt; fe0 = fe_cnt;
        send_byte(8'h15, 1'b1, 1'b0, 1'b0, f);
        checks++;
        if (fe_cnt - fe0 != 1 || fe_cyc != f + LAT + 1) begin
            errors++; $display("[TB] FAIL err_parity got %0d pulses at %0d expected 1 at %0d", fe_cnt - fe0, fe_cyc, f + LAT + 1);
        end
        send_byte(8'h15, 1'b0, 1'b1, 1'b0, f);
        ps2_data = 1'b1;
        checks++;
        if (fe_cnt - fe0 != 2 || fe_cyc != f + LAT + 1) begin
            errors++; $display("[TB] FAIL err_stop got %0d pulses at %0d expected 2 at %0d", fe_cnt - fe0, fe_cyc, f + LAT + 1);
        end
        checks++;
        if (rx_cnt != rx0 || scan_code !== m_scan) begin
            errors++; $display("[TB] FAIL err_no_rx got %0d pulses scan %h expected 0 pulses scan %h", rx_cnt - rx0, scan_code, m_scan);
        end
        run_list("err_pending_kept", '{8'h33});
    endtask

    task automatic test_timeout();
        int f, rx0, fe0;
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        rx0 = rx_cnt; fe0 = fe_cnt;
        send_bits(mk_frame(b, 1'b0, 1'b0), 5, 1'b0, f);
        ps2_data = 1'b1;
        wait_cycles(LAT + TO + 20);
        checks++;
        if (fe_cnt - fe0 != 1 || fe_cyc != f + LAT + TO) begin
            errors++; $display("[TB] FAIL timeout got %0d pulses at %0d expected 1 at %0d", fe_cnt - fe0, fe_cyc, f + LAT + TO);
        end
        checks++;
        if (rx_cnt != rx0) begin errors++; $display("[TB] FAIL timeout_no_rx got %0d pulses expected 0", rx_cnt - rx0); end
        run_list("after_timeout", '{8'h24});
    endtask

    task automatic test_glitch_reset();
        int f, fe0;
        logic [7:0] b;
        b = 8'($urandom_range(1, 127));
        fe0 = fe_cnt;
        send_byte(b, 1'b0, 1'b0, 1'b1, f);
        void'(model_decode(b));
        checks++;
        if (rx_last !== b || rx_cyc != f + LAT + 1 || fe_cnt != fe0) begin
            errors++; $display("[TB] FAIL glitch_rx got %h at %0d errs %0d expected %h at %0d errs 0", rx_last, rx_cyc, fe_cnt - fe0, b, f + LAT + 1);
        end
        checks++;
        if (scan_code !== m_scan) begin errors++; $display("[TB] FAIL glitch_scan got %h expected %h", scan_code, m_scan); end
        send_bits(mk_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0), 5, 1'b0, f);
        wait_cycles(5);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        ps2_data = 1'b1;
        m_scan = 8'h00;
        m_pending = 1'b0;
        checks++;
        if (scan_code !== 8'h00 || rx_byte !== 8'h00) begin
            errors++; $display("[TB] FAIL rst_mid_frame got scan %h rx %h expected 00 00", scan_code, rx_byte);
        end
        fe0 = fe_cnt;
        wait_cycles(LAT + TO + 20);
        checks++;
        if (fe_cnt != fe0) begin errors++; $display("[TB] FAIL rst_idle got %0d errs expected 0", fe_cnt - fe0); end
        send_bits(11'h7FF, 3, 1'b0, f);
        wait_cycles(10);
        run_list("after_rst", '{8'($urandom_range(1, 127))});
    endtask

    task automatic test_random_sequence();
        logic [7:0] seq[$];
        logic [7:0] shadow;
        int r;
        shadow = m_scan;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) seq.push_back(8'hF0);
            else if (r == 2) seq.push_back(8'hE0);
            else if (r < 5 && shadow != 8'h00) seq.push_back(shadow);
            else begin
                shadow = 8'($urandom_range(1, 127));
                seq.push_back(shadow);
            end
        end
        run_list("random", seq);
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        test_reset();
        test_single_make();
        test_make_break();
        test_no_break_switch();
        test_frame_errors();
        test_timeout();
        test_glitch_reset();
        test_random_sequence();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
